// File: rtl/zbt_pkg.sv
// Shared constants for the ZBT image-load path: bus widths, read latency,
// default image size and the arbiter state encoding.
package zbt_pkg;

  localparam int ZBT_ADDR_W        = 19;
  localparam int ZBT_DATA_W        = 36;
  localparam int ZBT_RD_LATENCY    = 2;
  localparam int IMG_WORDS_DEFAULT = 19200;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/zbt_wr_fifo.sv
// Small synchronous FIFO buffering packed words while the display owns the ZBT.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module zbt_wr_fifo
  import zbt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [ZBT_DATA_W-1:0] i_data,
  output logic [ZBT_DATA_W-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ZBT_DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W:0]        r_wrPtr;
  logic [PTR_W:0]        r_rdPtr;

  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                   (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
  assign o_data  = r_mem[r_rdPtr[PTR_W-1:0]];

  // Flush discards everything, including a push arriving in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wrPtr[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/zbt_write_arbiter.sv
// Shares one ZBT port between display reads (absolute priority) and buffered
// image-load writes, tracking load progress through IDLE/LOAD/DONE.
module zbt_write_arbiter
  import zbt_pkg::*;
#(
  parameter int IMG_WORDS  = IMG_WORDS_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_wr_valid,
  input  logic [ZBT_DATA_W-1:0] i_wr_data,
  input  logic                  i_rd_req,
  input  logic [ZBT_ADDR_W-1:0] i_rd_addr,
  output logic                  o_rd_valid,
  output logic [ZBT_DATA_W-1:0] o_rd_data,
  output logic [ZBT_ADDR_W-1:0] o_zbt_addr,
  output logic                  o_zbt_we,
  output logic [ZBT_DATA_W-1:0] o_zbt_wdata,
  input  logic [ZBT_DATA_W-1:0] i_zbt_rdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow
);

  localparam logic [ZBT_ADDR_W-1:0] LAST_ADDR = ZBT_ADDR_W'(IMG_WORDS - 1);

  logic [1:0]              r_state;
  logic [ZBT_ADDR_W-1:0]   r_wrAddr;
  logic [ZBT_RD_LATENCY:0] r_rdPipe;

  logic                  w_load;
  logic                  w_issueWrite;
  logic                  w_lastWrite;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_flush;
  logic [ZBT_DATA_W-1:0] w_fifoData;
  logic                  w_fifoFull;
  logic                  w_fifoEmpty;

  // A start cycle never writes: the FIFO is being flushed underneath it.
  assign w_load       = (r_state == ST_LOAD);
  assign w_issueWrite = w_load && !i_start && !i_rd_req && !w_fifoEmpty;
  assign w_lastWrite  = w_issueWrite && (r_wrAddr == LAST_ADDR);
  assign w_push       = w_load && !i_start && i_wr_valid && (!w_fifoFull || w_issueWrite);
  assign w_drop       = w_load && !i_start && i_wr_valid && w_fifoFull && !w_issueWrite;
  assign w_flush      = i_start || w_lastWrite;
  assign o_busy       = w_load;

  zbt_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_issueWrite),
    .i_flush (w_flush),
    .i_data  (i_wr_data),
    .o_data  (w_fifoData),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_wrAddr   <= '0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else if (i_start) begin
      r_state    <= ST_LOAD;
      r_wrAddr   <= '0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (w_lastWrite) begin
        r_state <= ST_DONE;
        o_done  <= 1'b1;
      end else if (w_issueWrite) begin
        r_wrAddr <= r_wrAddr + ZBT_ADDR_W'(1);
      end
      if (w_drop) o_overflow <= 1'b1;
    end
  end

  // Idle cycles only drop the write enable; address and data hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_zbt_addr  <= '0;
      o_zbt_we    <= 1'b0;
      o_zbt_wdata <= '0;
    end else if (i_rd_req) begin
      o_zbt_addr <= i_rd_addr;
      o_zbt_we   <= 1'b0;
    end else if (w_issueWrite) begin
      o_zbt_addr  <= r_wrAddr;
      o_zbt_we    <= 1'b1;
      o_zbt_wdata <= w_fifoData;
    end else begin
      o_zbt_we <= 1'b0;
    end
  end

  // One stage per edge of ZBT latency plus the address launch, then capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdPipe   <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      r_rdPipe   <= {r_rdPipe[ZBT_RD_LATENCY-1:0], i_rd_req};
      o_rd_valid <= r_rdPipe[ZBT_RD_LATENCY];
      if (r_rdPipe[ZBT_RD_LATENCY]) o_rd_data <= i_zbt_rdata;
    end
  end

endmodule

// File: tb/tb_zbt_write_arbiter.sv
// Directed bench for zbt_write_arbiter with a two-edge-latency ZBT model and
// logs of every write pulse and read return, checked against hand-derived values.
module tb_zbt_write_arbiter;

  typedef struct {
    int          cyc;
    logic [18:0] addr;
    logic [35:0] data;
  } logRec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        wrValid = 1'b0;
  logic [35:0] wrData = '0;
  logic        rdReq = 1'b0;
  logic [18:0] rdAddr = '0;
  logic        rdValid;
  logic [35:0] rdData;
  logic [18:0] zbtAddr;
  logic        zbtWe;
  logic [35:0] zbtWdata;
  logic [35:0] zbtRdata = '0;
  logic        busy;
  logic        done;
  logic        overflow;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logRec_t     wrLog[$];
  logRec_t     rdLog[$];
  logic [18:0] zbtAddrD1 = '0;
  int          sCyc[10];
  int          rCyc[30];

  zbt_write_arbiter #(
    .IMG_WORDS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk       (clock),
    .i_reset     (reset),
    .i_start     (start),
    .i_wr_valid  (wrValid),
    .i_wr_data   (wrData),
    .i_rd_req    (rdReq),
    .i_rd_addr   (rdAddr),
    .o_rd_valid  (rdValid),
    .o_rd_data   (rdData),
    .o_zbt_addr  (zbtAddr),
    .o_zbt_we    (zbtWe),
    .o_zbt_wdata (zbtWdata),
    .i_zbt_rdata (zbtRdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_overflow  (overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [35:0] modelWord(input logic [18:0] a);
    return {17'h0A5A5, a};
  endfunction

  // ZBT model: data for an address appears two edges after it was launched.
  always @(posedge clock) begin
    cyc       <= cyc + 1;
    zbtAddrD1 <= zbtAddr;
    zbtRdata  <= modelWord(zbtAddrD1);
  end

  always @(negedge clock) begin
    if (zbtWe)   wrLog.push_back('{cyc, zbtAddr, zbtWdata});
    if (rdValid) rdLog.push_back('{cyc, 19'd0, rdData});
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic w, input logic [35:0] d,
                               input logic r, input logic [18:0] ra);
    start   = s;
    wrValid = w;
    wrData  = d;
    rdReq   = r;
    rdAddr  = ra;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 36'h0, 1'b0, 19'h0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_addr"},   64'(zbtAddr),  64'h0);
    checkOutput({tag, "_we"},     64'(zbtWe),    64'h0);
    checkOutput({tag, "_wdata"},  64'(zbtWdata), 64'h0);
    checkOutput({tag, "_rvalid"}, 64'(rdValid),  64'h0);
    checkOutput({tag, "_rdata"},  64'(rdData),   64'h0);
    checkOutput({tag, "_busy"},   64'(busy),     64'h0);
    checkOutput({tag, "_done"},   64'(done),     64'h0);
    checkOutput({tag, "_ovf"},    64'(overflow), 64'h0);
  endtask

  initial begin
    logic [35:0] strobeData [3];
    strobeData[0] = 36'h0_5000_0002;
    strobeData[1] = 36'h0_5000_0005;
    strobeData[2] = 36'h0_5000_0008;

    // Reset, then four spaced strobes with no reads.
    reset = 1'b1;
    idle(3);
    checkAllZero("rst");
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 36'h0, 1'b0, 19'h0);
    wrLog.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 36'h0_4433_2211 + 36'(i), 1'b0, 19'h0);
      sCyc[i] = cyc;
      idle(3);
    end
    checkOutput("t1_busy", 64'(busy), 64'h1);
    checkOutput("t1_nwr", 64'(wrLog.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wrLog.size()) begin
        checkOutput("t1_cyc",  64'(wrLog[i].cyc),  64'(sCyc[i] + 1));
        checkOutput("t1_addr", 64'(wrLog[i].addr), 64'(i));
        checkOutput("t1_data", 64'(wrLog[i].data), 64'(36'h0_4433_2211 + 36'(i)));
      end
    end

    // Ten back-to-back reads block three writes until the reads end.
    applyStimulus(1'b1, 1'b0, 36'h0, 1'b0, 19'h0);
    wrLog.delete();
    rdLog.delete();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, (k == 2 || k == 5 || k == 8), 36'h0_5000_0000 + 36'(k),
                    1'b1, 19'h100 + 19'(k));
      rCyc[k] = cyc;
    end
    idle(8);
    checkOutput("t2_nwr", 64'(wrLog.size()), 64'd3);
    for (int j = 0; j < 3; j++) begin
      if (j < wrLog.size()) begin
        checkOutput("t2_wcyc",  64'(wrLog[j].cyc),  64'(rCyc[9] + 1 + j));
        checkOutput("t2_waddr", 64'(wrLog[j].addr), 64'(j));
        checkOutput("t2_wdata", 64'(wrLog[j].data), 64'(strobeData[j]));
      end
    end
    checkOutput("t2_nrd", 64'(rdLog.size()), 64'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < rdLog.size()) begin
        checkOutput("t2_rcyc",  64'(rdLog[k].cyc),  64'(rCyc[k] + 3));
        checkOutput("t2_rdata", 64'(rdLog[k].data), 64'(modelWord(19'h100 + 19'(k))));
      end
    end
    checkOutput("t2_ovf", 64'(overflow), 64'h0);

    // Thirty reads with six strobes overflow a four-deep buffer.
    applyStimulus(1'b1, 1'b0, 36'h0, 1'b0, 19'h0);
    wrLog.delete();
    rdLog.delete();
    for (int k = 0; k < 30; k++)
      applyStimulus(1'b0, (k % 4 == 3) && (k < 24), 36'h0_6000_0000 + 36'(k),
                    1'b1, 19'h200 + 19'(k));
    idle(8);
    checkOutput("t3_nwr", 64'(wrLog.size()), 64'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < wrLog.size()) begin
        checkOutput("t3_addr", 64'(wrLog[j].addr), 64'(j));
        checkOutput("t3_data", 64'(wrLog[j].data), 64'(36'h0_6000_0003 + 36'(4 * j)));
      end
    end
    checkOutput("t3_ovf", 64'(overflow), 64'h1);
    checkOutput("t3_nrd", 64'(rdLog.size()), 64'd30);
    wrLog.delete();
    applyStimulus(1'b0, 1'b1, 36'h0_7000_0000, 1'b0, 19'h0);
    idle(3);
    checkOutput("t3_nwr_next", 64'(wrLog.size()), 64'd1);
    if (wrLog.size() > 0) checkOutput("t3_addr_next", 64'(wrLog[0].addr), 64'd4);

    // Whole eight-word image, then two surplus strobes.
    applyStimulus(1'b1, 1'b0, 36'h0, 1'b0, 19'h0);
    wrLog.delete();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 36'h0_8000_0000 + 36'(i), 1'b0, 19'h0);
      sCyc[i] = cyc;
      if (i == 7) begin
        checkOutput("t4_done_pre", 64'(done), 64'h0);
        checkOutput("t4_busy_pre", 64'(busy), 64'h1);
      end
      if (i == 8) begin
        checkOutput("t4_done", 64'(done), 64'h1);
        checkOutput("t4_busy", 64'(busy), 64'h0);
      end
    end
    idle(4);
    checkOutput("t4_nwr", 64'(wrLog.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wrLog.size()) begin
        checkOutput("t4_cyc",  64'(wrLog[i].cyc),  64'(sCyc[i] + 1));
        checkOutput("t4_addr", 64'(wrLog[i].addr), 64'(i));
        checkOutput("t4_data", 64'(wrLog[i].data), 64'(36'h0_8000_0000 + 36'(i)));
      end
    end
    checkOutput("t4_done_hold", 64'(done), 64'h1);

    // Restart after DONE, restart clearing overflow, then reset mid-load.
    applyStimulus(1'b1, 1'b0, 36'h0, 1'b0, 19'h0);
    checkOutput("t5_done_clr", 64'(done), 64'h0);
    checkOutput("t5_busy", 64'(busy), 64'h1);
    for (int k = 0; k < 6; k++)
      applyStimulus(1'b0, (k < 5), 36'h0_9000_0000 + 36'(k), 1'b1, 19'h300 + 19'(k));
    checkOutput("t5_ovf_set", 64'(overflow), 64'h1);
    applyStimulus(1'b1, 1'b0, 36'h0, 1'b0, 19'h0);
    checkOutput("t5_ovf_clr", 64'(overflow), 64'h0);
    wrLog.delete();
    idle(4);
    checkOutput("t5_flushed", 64'(wrLog.size()), 64'd0);
    applyStimulus(1'b0, 1'b1, 36'h0_9000_00AA, 1'b0, 19'h0);
    idle(2);
    checkOutput("t5_nwr", 64'(wrLog.size()), 64'd1);
    if (wrLog.size() > 0) begin
      checkOutput("t5_addr", 64'(wrLog[0].addr), 64'd0);
      checkOutput("t5_data", 64'(wrLog[0].data), 64'h0_9000_00AA);
    end
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, (k < 2), 36'h0_A000_0000 + 36'(k), 1'b1, 19'h400 + 19'(k));
    reset = 1'b1;
    idle(1);
    checkAllZero("t5_rst");
    reset = 1'b0;
    wrLog.delete();
    rdLog.delete();
    idle(8);
    checkOutput("t5_rst_nwr", 64'(wrLog.size()), 64'd0);
    checkOutput("t5_rst_nrd", 64'(rdLog.size()), 64'd0);
    checkOutput("t5_rst_busy", 64'(busy), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zbt_write_arbiter.md
ZBT_WRITE_ARBITER -- requirements
Module: zbt_write_arbiter

Interface
REQ-001 Parameter IMG_WORDS, default 19200, meaning: number of 36-bit words in one image (320x240 bytes / 4).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning: write-buffer depth in words (power of two).
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse: begin loading an image at ZBT address 0.
REQ-006 wr_valid  input  1  one-cycle strobe; packed word from the byte packer is valid.
REQ-007 wr_data  input  36  packed word; bits [35:32] are always 0.
REQ-008 rd_req  input  1  display read request, sampled each cycle.
REQ-009 rd_addr  input  19  display read address.
REQ-010 rd_valid  output  1  one-cycle strobe; rd_data holds returned word.
REQ-011 rd_data  output  36  read word.
REQ-012 zbt_addr  output  19  registered ZBT address.
REQ-013 zbt_we  output  1  registered ZBT write enable, active-high.
REQ-014 zbt_wdata  output  36  registered ZBT write data.
REQ-015 zbt_rdata  input  36  ZBT read data.
REQ-016 busy  output  1  high while in LOAD.
REQ-017 done  output  1  sticky; image fully written.
REQ-018 overflow  output  1  sticky; at least one packed word dropped.

Function
REQ-019 States: IDLE, LOAD, DONE.
REQ-020 start in any state: next state LOAD; write address 0; FIFO flushed; done and overflow cleared; wr_valid in the same cycle is dropped.
REQ-021 In IDLE or DONE, wr_valid is ignored and overflow is unaffected.
REQ-022 In LOAD, wr_valid pushes wr_data into the FIFO.
REQ-023 If the FIFO is full and not popping in the same cycle, wr_valid drops the word and sets overflow. Push and pop of a full FIFO in the same cycle are both accepted.
REQ-024 Arbitration per cycle: rd_req has absolute priority. Otherwise, in LOAD with a non-empty FIFO, one write is issued.
REQ-025 A read cycle drives zbt_addr=rd_addr and zbt_we=0 on the next edge.
REQ-026 A write cycle drives zbt_addr=write address, zbt_we=1 and zbt_wdata=FIFO head on the next edge, pops the FIFO, and increments the write address.
REQ-027 An idle cycle drives zbt_we=0. zbt_addr and zbt_wdata hold their previous values.
REQ-028 zbt_rdata is valid two edges after the edge that launched the read address. The block registers it, so rd_valid=1 and rd_data=word exactly 3 cycles after rd_req was sampled.
REQ-029 Back-to-back rd_req is fully pipelined, one result per cycle, in order.
REQ-030 The write address counts 0..IMG_WORDS-1 and does not wrap.
REQ-031 When the write to address IMG_WORDS-1 issues: next state DONE; done=1; FIFO flushed.
REQ-032 busy=1 exactly when the state is LOAD.
REQ-033 Reads are serviced in every state, including during and after reset release.
REQ-034 A read in flight when start arrives still returns its data at its scheduled cycle.

Reset
REQ-035 On reset: state IDLE, FIFO empty, write address 0, read pipeline cleared.
REQ-036 On reset: zbt_addr=0, zbt_we=0, zbt_wdata=0, rd_valid=0, rd_data=0, busy=0, done=0, overflow=0.
REQ-037 Reset mid-LOAD abandons the load; in-flight read results are discarded (no rd_valid).

Structure
REQ-038 Shared package zbt_pkg holds ZBT_ADDR_W=19, ZBT_DATA_W=36, ZBT_RD_LATENCY=2, IMG_WORDS default and the state enumeration.
REQ-039 One sub-module, zbt_wr_fifo: synchronous FIFO with FIFO_DEPTH entries of 36 bits, with push, pop, flush, full and empty signals.

Verification
REQ-040 Reset, then start, then 4 wr_valid strobes 4 cycles apart with data 0x0_44332211 upward, no rd_req -> zbt_we pulses at addresses 0..3 with matching data, each 1 cycle after its strobe; busy=1.
REQ-041 rd_req held 10 cycles at addresses 0x100..0x109 while 3 wr_valid strobes arrive -> no zbt_we during the reads. The 3 writes issue on the 3 cycles after the reads. 10 rd_valid pulses 3 cycles after each request, in order. overflow=0.
REQ-042 rd_req held 30 cycles while 6 wr_valid strobes arrive, with FIFO_DEPTH=4 -> 4 words written afterward, overflow=1, write address ends at 4.
REQ-043 IMG_WORDS=8: 10 strobes after start -> writes to addresses 0..7; done=1 and busy=0 one cycle after the address-7 write; the last 2 strobes produce no zbt_we.
REQ-044 A second start after DONE, plus reset asserted during a LOAD with 2 words buffered -> write address restarts at 0, done and overflow are cleared; after reset all outputs are 0 and no buffered write issues.
